// File: rtl/cgp_check_pkg.sv
// Shared definitions for the exhaustive equivalence checker: FSM encoding and settle-timer width.
package cgp_check_pkg;

  localparam int TIMER_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WAIT  = 2'd1;
  localparam state_t ST_CHECK = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/equiv_vec_seq.sv
// Stimulus vector counter plus per-vector settle timer for the equivalence checker.
module equiv_vec_seq
  import cgp_check_pkg::*;
#(
  parameter int IN_W   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            advance,
  output logic [IN_W-1:0] stim,
  output logic            last_vec,
  output logic            settle_expired
);

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(SETTLE - 1);

  logic [TIMER_W-1:0] timer;

  // The timer only counts down while non-zero, so it idles at zero outside WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim  <= '0;
      timer <= '0;
    end else if (load) begin
      stim  <= '0;
      timer <= RELOAD;
    end else if (advance) begin
      stim  <= stim + IN_W'(1);
      timer <= RELOAD;
    end else if (timer != '0) begin
      timer <= timer - TIMER_W'(1);
    end
  end

  assign last_vec       = &stim;
  assign settle_expired = (timer == '0);

endmodule

// File: rtl/exhaustive_equiv_checker.sv
// Walks every input vector, compares DUT against golden after a settle delay, and reports the result.
module exhaustive_equiv_checker
  import cgp_check_pkg::*;
#(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1,
  parameter int CNT_W  = IN_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop_on_fail,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] dut_out,
  input  logic [OUT_W-1:0] ref_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_fail_valid,
  output logic [IN_W-1:0]  first_fail_vec
);

  state_t state;
  logic   stop_latched;
  logic   mismatch;
  logic   accept;
  logic   finish;
  logic   load;
  logic   advance;
  logic   last_vec;
  logic   settle_expired;

  assign mismatch = (dut_out != ref_out);
  assign accept   = start && (state == ST_IDLE || state == ST_DONE);
  assign finish   = (mismatch && stop_latched) || last_vec;
  assign load     = accept;
  assign advance  = (state == ST_CHECK) && !finish;

  equiv_vec_seq #(
    .IN_W   (IN_W),
    .SETTLE (SETTLE)
  ) u_seq (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (load),
    .advance        (advance),
    .stim           (stim),
    .last_vec       (last_vec),
    .settle_expired (settle_expired)
  );

  // pass must include the compare taken on the same edge that ends the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      stop_latched     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_cnt          <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state            <= ST_WAIT;
            stop_latched     <= stop_on_fail;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_cnt          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
          end
        end
        ST_WAIT: begin
          if (settle_expired) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= stim;
            end
          end
          if (finish) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0) && !mismatch;
          end else begin
            state <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exhaustive_equiv_checker.sv
// Directed bench: SETTLE=1 and SETTLE=3 instances checked against hand-computed timing and results.
module tb_exhaustive_equiv_checker;

  logic       clk;
  logic       rst_n;
  int         tests_run;
  int         tests_failed;

  logic       start1, sof1, use_or1;
  logic [1:0] stim1;
  logic       dut_out1, ref_out1;
  logic       busy1, done1, pass1, ffv1;
  logic [2:0] err1;
  logic [1:0] ffvec1;

  logic       start3, sof3, glitch3;
  logic [1:0] stim3;
  logic       dut_out3, ref_out3;
  logic       busy3, done3, pass3, ffv3;
  logic [2:0] err3;
  logic [1:0] ffvec3;

  // Modelled netlists: golden is AND, DUT is AND or OR; dut3 can glitch outside CHECK.
  assign ref_out1 = &stim1;
  assign dut_out1 = use_or1 ? |stim1 : &stim1;
  assign ref_out3 = &stim3;
  assign dut_out3 = (&stim3) ^ glitch3;

  exhaustive_equiv_checker #(.IN_W(2), .OUT_W(1), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop_on_fail(sof1), .stim(stim1),
    .dut_out(dut_out1), .ref_out(ref_out1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_fail_valid(ffv1), .first_fail_vec(ffvec1));

  exhaustive_equiv_checker #(.IN_W(2), .OUT_W(1), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .stop_on_fail(sof3), .stim(stim3),
    .dut_out(dut_out3), .ref_out(ref_out3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .first_fail_valid(ffv3), .first_fail_vec(ffvec3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench 1 time unit after edge E, the edge that accepts start.
  task automatic pulse_start1();
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    tests_run++; if (stim1 !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_stim: got %0d want 0", stim1); end
    tests_run++; if (busy1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %0b want 0", busy1); end
    tests_run++; if (done1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %0b want 0", done1); end
    tests_run++; if (pass1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pass: got %0b want 0", pass1); end
    tests_run++; if (err1 !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_err: got %0d want 0", err1); end
    tests_run++; if (ffv1 !== 1'b0 || ffvec1 !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_ff: got %0b/%0d want 0/0", ffv1, ffvec1); end
    tests_run++; if (busy3 !== 1'b0 || done3 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_dut3: got busy %0b done %0b want 0/0", busy3, done3); end
  endtask

  task automatic test_match_run();
    use_or1 = 1'b0; sof1 = 1'b0;
    pulse_start1();
    tests_run++; if (busy1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL match_busy: got %0b want 1", busy1); end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step(1);
      tests_run++; if (stim1 !== 2'(k / 2)) begin tests_failed++; $display("[TB] FAIL match_stim_e%0d: got %0d want %0d", k, stim1, k / 2); end
      tests_run++; if (done1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL match_early_done_e%0d: got %0b want 0", k, done1); end
    end
    step(1);
    tests_run++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL match_done: got done %0b busy %0b want 1/0", done1, busy1); end
    tests_run++; if (pass1 !== 1'b1 || err1 !== 3'd0 || ffv1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL match_result: got pass %0b err %0d ffv %0b want 1/0/0", pass1, err1, ffv1); end
    tests_run++; if (stim1 !== 2'd3) begin tests_failed++; $display("[TB] FAIL match_stim_hold: got %0d want 3", stim1); end
  endtask

  task automatic test_or_fault();
    use_or1 = 1'b1; sof1 = 1'b0;
    pulse_start1();
    step(7);
    tests_run++; if (done1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL or_done_e7: got %0b want 0", done1); end
    step(1);
    tests_run++; if (done1 !== 1'b1 || pass1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL or_done: got done %0b pass %0b want 1/0", done1, pass1); end
    tests_run++; if (err1 !== 3'd2) begin tests_failed++; $display("[TB] FAIL or_err: got %0d want 2", err1); end
    tests_run++; if (ffv1 !== 1'b1 || ffvec1 !== 2'd1) begin tests_failed++; $display("[TB] FAIL or_first: got %0b/%0d want 1/1", ffv1, ffvec1); end
  endtask

  task automatic test_stop_on_fail();
    use_or1 = 1'b1; sof1 = 1'b1;
    pulse_start1();
    sof1 = 1'b0;
    step(3);
    tests_run++; if (done1 !== 1'b0 || busy1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL sof_e3: got done %0b busy %0b want 0/1", done1, busy1); end
    step(1);
    tests_run++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL sof_e4: got done %0b busy %0b want 1/0", done1, busy1); end
    tests_run++; if (stim1 !== 2'd1 || err1 !== 3'd1) begin tests_failed++; $display("[TB] FAIL sof_state: got stim %0d err %0d want 1/1", stim1, err1); end
    tests_run++; if (ffvec1 !== 2'd1 || ffv1 !== 1'b1 || pass1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL sof_result: got vec %0d ffv %0b pass %0b want 1/1/0", ffvec1, ffv1, pass1); end
  endtask

  task automatic test_settle3();
    @(negedge clk);
    start3 = 1'b1; sof3 = 1'b0;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    glitch3 = 1'b1;
    for (int k = 1; k < 16; k++) begin
      step(1);
      glitch3 = ((k % 4) != 3);
      tests_run++; if (stim3 !== 2'(k / 4) || done3 !== 1'b0) begin tests_failed++; $display("[TB] FAIL s3_e%0d: got stim %0d done %0b want %0d/0", k, stim3, done3, k / 4); end
    end
    step(1);
    glitch3 = 1'b0;
    tests_run++; if (done3 !== 1'b1 || pass3 !== 1'b1 || err3 !== 3'd0) begin tests_failed++; $display("[TB] FAIL s3_done: got done %0b pass %0b err %0d want 1/1/0", done3, pass3, err3); end
  endtask

  task automatic test_back_to_back();
    use_or1 = 1'b1; sof1 = 1'b0;
    pulse_start1();
    step(2);
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    step(4);
    tests_run++; if (done1 !== 1'b0 || stim1 !== 2'd3) begin tests_failed++; $display("[TB] FAIL ign_e7: got done %0b stim %0d want 0/3", done1, stim1); end
    step(1);
    tests_run++; if (done1 !== 1'b1 || err1 !== 3'd2 || ffvec1 !== 2'd1) begin tests_failed++; $display("[TB] FAIL ign_done: got done %0b err %0d vec %0d want 1/2/1", done1, err1, ffvec1); end
    pulse_start1();
    tests_run++; if (done1 !== 1'b0 || err1 !== 3'd0 || ffv1 !== 1'b0 || busy1 !== 1'b1 || stim1 !== 2'd0) begin tests_failed++; $display("[TB] FAIL restart_clear: got done %0b err %0d ffv %0b busy %0b stim %0d want 0/0/0/1/0", done1, err1, ffv1, busy1, stim1); end
    step(8);
    tests_run++; if (done1 !== 1'b1 || err1 !== 3'd2 || ffvec1 !== 2'd1 || pass1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart_done: got done %0b err %0d vec %0d pass %0b want 1/2/1/0", done1, err1, ffvec1, pass1); end
  endtask

  task automatic test_mid_run_reset();
    use_or1 = 1'b1; sof1 = 1'b0;
    pulse_start1();
    step(5);
    tests_run++; if (err1 !== 3'd1) begin tests_failed++; $display("[TB] FAIL mrr_pre_err: got %0d want 1", err1); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (err1 !== 3'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL mrr_async: got err %0d busy %0b done %0b want 0/0/0", err1, busy1, done1); end
    tests_run++; if (stim1 !== 2'd0 || ffv1 !== 1'b0 || ffvec1 !== 2'd0 || pass1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL mrr_regs: got stim %0d ffv %0b vec %0d pass %0b want 0/0/0/0", stim1, ffv1, ffvec1, pass1); end
    step(2);
    tests_run++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL mrr_hold: got done %0b busy %0b want 0/0", done1, busy1); end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start1();
    step(8);
    tests_run++; if (done1 !== 1'b1 || err1 !== 3'd2 || pass1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL mrr_rerun: got done %0b err %0d pass %0b want 1/2/0", done1, err1, pass1); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0;
    start1 = 1'b0; sof1 = 1'b0; use_or1 = 1'b0;
    start3 = 1'b0; sof3 = 1'b0; glitch3 = 1'b0;
    step(2);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    test_reset();
    test_match_run();
    test_or_fault();
    test_stop_on_fail();
    test_settle3();
    test_back_to_back();
    test_mid_run_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
